seven_segment_reader: RTL and testbench
=======================================

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port seg, input, 7, segment lines, active-high, seg[0]=a through seg[6]=g.
REQ-005 SHALL have port digit_en, input, 4, digit select of a multiplexed 4-digit display, active-high, legal only when one-hot.
REQ-006 SHALL have port out_valid, output, 1, one-cycle pulse marking an accepted digit.
REQ-007 SHALL have port out_digit, output, 2, index of the accepted digit (0..3).
REQ-008 SHALL have port out_value, output, 4, decoded hex numeral of the accepted digit.
REQ-009 SHALL have port out_error, output, 1, accepted pattern is not one of the 16 legal glyphs.
REQ-010 SHALL have port numerals, output, 16, last accepted values, nibble i belongs to digit i.
REQ-011 SHALL have port frame_valid, output, 1, one-cycle pulse when all four digits have been accepted since the previous frame_valid or reset.

Function
REQ-012 SHALL register seg and digit_en once (sample stage) before any comparison; accepted results appear no earlier than STABLE_CYCLES+1 cycles after inputs settle.
REQ-013 SHALL keep a stability counter: sample equal to previous sample and digit_en one-hot -> increment (saturating); otherwise -> clear to 0.
REQ-014 SHALL accept a digit exactly once per stable period, on the cycle the counter reaches STABLE_CYCLES-1; further identical samples SHALL NOT re-accept.
REQ-015 SHALL decode seg (hex) as 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
REQ-016 SHALL on acceptance of an illegal pattern assert out_valid with out_error=1, out_value=0, and leave numerals and the frame mask unchanged.
REQ-017 SHALL on legal acceptance write out_value into numerals nibble out_digit and set that digit's bit in a 4-bit frame mask.
REQ-018 SHALL pulse frame_valid the cycle after the mask becomes 4'b1111 and clear the mask in that same cycle; a same-cycle acceptance SHALL land in the new mask.
REQ-019 SHALL treat digit_en of zero or more than one bit set as blanking: no acceptance, counter cleared.
REQ-020 SHALL hold out_digit, out_value, out_error stable between out_valid pulses.

Reset
REQ-021 SHALL on rst clear sample registers, counter, frame mask, numerals (16'h0000), out_valid, out_digit, out_value, out_error, frame_valid.
REQ-022 SHALL, if rst is asserted mid-stable-period, discard that period; acceptance requires a full STABLE_CYCLES run after rst deasserts.

Structure
REQ-023 SHALL place segment glyph constants and the 2-bit digit index type in a shared package, reused by the segment drivers.
REQ-024 SHALL implement glyph-to-numeral decode as combinational sub-module seven_segment_glyph_decode (seg in, value and illegal flag out).

Verification
REQ-025 SHALL cover: seg=7'h5B, digit_en=4'b0100 held 10 cycles -> single out_valid, out_digit=2, out_value=2, out_error=0, numerals[11:8]=2.
REQ-026 SHALL cover: seg=7'h7F held only 3 cycles with STABLE_CYCLES=4 -> no out_valid.
REQ-027 SHALL cover: digits 0..3 driven with 06,4F,66,6D, each held 6 cycles -> four out_valid pulses, numerals=16'h5431, one frame_valid after the fourth.
REQ-028 SHALL cover: seg=7'h01, digit_en=4'b0001 held 6 cycles -> out_valid with out_error=1, numerals unchanged, no mask update.
REQ-029 SHALL cover: digit_en=4'b0011 with seg=7'h3F held 10 cycles -> no out_valid.
REQ-030 SHALL cover: rst pulsed on cycle 3 of a stable 7'h6F run -> no acceptance until a fresh 4-cycle run completes, numerals=0 after rst.

Source files
------------

// File: rtl/seven_segment_reader_pkg.sv
// Shared definitions for the seven-segment display front end: glyph constants,
// digit index type and the one-hot digit-select helper.
package seven_segment_reader_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned NIB_W  = 4;

    typedef logic [1:0] digit_idx_t;

    // Segment patterns, seg[0]=a .. seg[6]=g, active-high
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    // Index of the set bit of a one-hot digit select (caller guarantees one-hot)
    function automatic digit_idx_t onehot_to_idx(input logic [DIGITS-1:0] en);
        digit_idx_t idx;
        idx = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (en[i]) idx = digit_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational glyph-to-hex decode; unknown patterns flag illegal with value 0.
module seven_segment_glyph_decode
    import seven_segment_reader_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [NIB_W-1:0] value_o,
    output logic             illegal_o
);

    // Table lookup of the 16 legal glyphs
    always_comb begin
        value_o   = '0;
        illegal_o = 1'b0;
        case (seg_i)
            GLYPH_0: value_o = 4'h0;
            GLYPH_1: value_o = 4'h1;
            GLYPH_2: value_o = 4'h2;
            GLYPH_3: value_o = 4'h3;
            GLYPH_4: value_o = 4'h4;
            GLYPH_5: value_o = 4'h5;
            GLYPH_6: value_o = 4'h6;
            GLYPH_7: value_o = 4'h7;
            GLYPH_8: value_o = 4'h8;
            GLYPH_9: value_o = 4'h9;
            GLYPH_A: value_o = 4'hA;
            GLYPH_B: value_o = 4'hB;
            GLYPH_C: value_o = 4'hC;
            GLYPH_D: value_o = 4'hD;
            GLYPH_E: value_o = 4'hE;
            GLYPH_F: value_o = 4'hF;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed 4-digit seven-segment display: samples the lines, waits
// for a stable pattern on one digit, decodes it and assembles full frames.
module seven_segment_reader
    import seven_segment_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEG_W-1:0]          seg,
    input  logic [DIGITS-1:0]         digit_en,
    output logic                      out_valid,
    output digit_idx_t                out_digit,
    output logic [NIB_W-1:0]          out_value,
    output logic                      out_error,
    output logic [DIGITS*NIB_W-1:0]   numerals,
    output logic                      frame_valid
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 2);

    logic [SEG_W-1:0]        seg_q, seg_prev_q;
    logic [DIGITS-1:0]       en_q, en_prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIGITS-1:0]       mask_q, mask_d;
    logic [DIGITS*NIB_W-1:0] numerals_q, numerals_d;
    logic                    out_valid_q, out_valid_d;
    digit_idx_t              out_digit_q, out_digit_d;
    logic [NIB_W-1:0]        out_value_q, out_value_d;
    logic                    out_error_q, out_error_d;
    logic                    frame_valid_q, frame_valid_d;

    logic                    stable_c;
    logic                    accept_c;
    digit_idx_t              idx_c;
    logic [NIB_W-1:0]        value_c;
    logic                    illegal_c;

    seven_segment_glyph_decode u_decode (
        .seg_i     (seg_q),
        .value_o   (value_c),
        .illegal_o (illegal_c)
    );

    // Stability counter; acceptance fires on the single step into STABLE_CYCLES-1
    always_comb begin
        stable_c = (seg_q == seg_prev_q) && (en_q == en_prev_q) && $onehot(en_q);
        cnt_d    = '0;
        if (stable_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        accept_c = stable_c && (cnt_q == CNT_ACCEPT);
        idx_c    = onehot_to_idx(en_q);
    end

    // Result, numeral store and frame-mask update
    always_comb begin
        out_valid_d   = accept_c;
        out_digit_d   = out_digit_q;
        out_value_d   = out_value_q;
        out_error_d   = out_error_q;
        numerals_d    = numerals_q;
        frame_valid_d = (mask_q == '1);
        mask_d        = (mask_q == '1) ? '0 : mask_q;
        if (accept_c) begin
            out_digit_d = idx_c;
            out_error_d = illegal_c;
            out_value_d = illegal_c ? '0 : value_c;
            if (!illegal_c) begin
                numerals_d[NIB_W*idx_c +: NIB_W] = value_c;
                mask_d = mask_d | (DIGITS'(1) << idx_c);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= '0;
            seg_prev_q    <= '0;
            en_q          <= '0;
            en_prev_q     <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            numerals_q    <= '0;
            out_valid_q   <= 1'b0;
            out_digit_q   <= '0;
            out_value_q   <= '0;
            out_error_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            seg_q         <= seg;
            seg_prev_q    <= seg_q;
            en_q          <= digit_en;
            en_prev_q     <= en_q;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            numerals_q    <= numerals_d;
            out_valid_q   <= out_valid_d;
            out_digit_q   <= out_digit_d;
            out_value_q   <= out_value_d;
            out_error_q   <= out_error_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_digit   = out_digit_q;
    assign out_value   = out_value_q;
    assign out_error   = out_error_q;
    assign numerals    = numerals_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with STABLE_CYCLES=4.
module tb_seven_segment_reader;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        out_valid;
    logic [1:0]  out_digit;
    logic [3:0]  out_value;
    logic        out_error;
    logic [15:0] numerals;
    logic        frame_valid;

    seven_segment_reader #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .digit_en    (digit_en),
        .out_valid   (out_valid),
        .out_digit   (out_digit),
        .out_value   (out_value),
        .out_error   (out_error),
        .numerals    (numerals),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  en;
        int          hold;
        int          exp_pulses;
        logic [1:0]  exp_digit;
        logic [3:0]  exp_value;
        logic        exp_error;
        logic [15:0] exp_num;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int checks;
    int failures;
    int cyc;
    int pulses;
    int frames;
    int first_pulse_cyc;
    int last_valid_cyc;
    int frame_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs observed 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            pulses++;
            last_valid_cyc = cyc;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
        end
        if (frame_valid === 1'b1) begin
            frames++;
            frame_cyc = cyc;
        end
    endtask

    task automatic clear_stats();
        cyc = 0; pulses = 0; frames = 0;
        first_pulse_cyc = -1; last_valid_cyc = -1; frame_cyc = -1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; seg = 7'h00; digit_en = 4'b0000;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] e, input int n);
        seg = s; digit_en = e;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0; failures = 0;
        clear_stats();

        vecs[0]  = '{7'h5B, 4'b0100, 10, 1, 2'd2, 4'h2, 1'b0, 16'h0200};
        vecs[1]  = '{7'h7F, 4'b0001,  3, 0, 2'd0, 4'h0, 1'b0, 16'h0000};
        vecs[2]  = '{7'h01, 4'b0001,  6, 1, 2'd0, 4'h0, 1'b1, 16'h0000};
        vecs[3]  = '{7'h3F, 4'b0011, 10, 0, 2'd0, 4'h0, 1'b0, 16'h0000};
        vecs[4]  = '{7'h3F, 4'b0000, 10, 0, 2'd0, 4'h0, 1'b0, 16'h0000};
        vecs[5]  = '{7'h77, 4'b1000,  4, 1, 2'd3, 4'hA, 1'b0, 16'hA000};
        vecs[6]  = '{7'h7C, 4'b0010,  5, 1, 2'd1, 4'hB, 1'b0, 16'h00B0};
        vecs[7]  = '{7'h5E, 4'b0100,  6, 1, 2'd2, 4'hD, 1'b0, 16'h0D00};
        vecs[8]  = '{7'h79, 4'b0001,  6, 1, 2'd0, 4'hE, 1'b0, 16'h000E};
        vecs[9]  = '{7'h71, 4'b1000,  6, 1, 2'd3, 4'hF, 1'b0, 16'hF000};
        vecs[10] = '{7'h39, 4'b0010,  6, 1, 2'd1, 4'hC, 1'b0, 16'h00C0};
        vecs[11] = '{7'h07, 4'b0001,  6, 1, 2'd0, 4'h7, 1'b0, 16'h0007};
        vecs[12] = '{7'h3F, 4'b0001,  6, 1, 2'd0, 4'h0, 1'b0, 16'h0000};
        vecs[13] = '{7'h7D, 4'b0100,  6, 1, 2'd2, 4'h6, 1'b0, 16'h0600};
        vecs[14] = '{7'h6F, 4'b0010,  6, 1, 2'd1, 4'h9, 1'b0, 16'h0090};
        vecs[15] = '{7'h7F, 4'b0100,  6, 1, 2'd2, 4'h8, 1'b0, 16'h0800};
        vecs[16] = '{7'h7E, 4'b0010,  6, 1, 2'd1, 4'h0, 1'b1, 16'h0000};
        vecs[17] = '{7'h66, 4'b1100,  8, 0, 2'd0, 4'h0, 1'b0, 16'h0000};

        // Reset state
        reset_dut();
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_digit",   32'(out_digit),   32'd0);
        check("rst_out_value",   32'(out_value),   32'd0);
        check("rst_out_error",   32'(out_error),   32'd0);
        check("rst_numerals",    32'(numerals),    32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);

        // Single-digit vectors, each from a fresh reset
        for (int v = 0; v < NVEC; v++) begin
            reset_dut();
            clear_stats();
            drive(vecs[v].seg, vecs[v].en, vecs[v].hold);
            drive(7'h00, 4'b0000, 4);
            check($sformatf("v%0d_pulses", v),  32'(pulses),         32'(vecs[v].exp_pulses));
            check($sformatf("v%0d_digit", v),   32'(out_digit),      32'(vecs[v].exp_digit));
            check($sformatf("v%0d_value", v),   32'(out_value),      32'(vecs[v].exp_value));
            check($sformatf("v%0d_error", v),   32'(out_error),      32'(vecs[v].exp_error));
            check($sformatf("v%0d_numerals", v), 32'(numerals),      32'(vecs[v].exp_num));
            check($sformatf("v%0d_frames", v),  32'(frames),         32'd0);
            if (vecs[v].exp_pulses == 1)
                check($sformatf("v%0d_latency", v), 32'(first_pulse_cyc), 32'd5);
        end

        // Full frame: digits 0..3 back to back
        reset_dut();
        clear_stats();
        drive(7'h06, 4'b0001, 6);
        drive(7'h4F, 4'b0010, 6);
        drive(7'h66, 4'b0100, 6);
        drive(7'h6D, 4'b1000, 6);
        drive(7'h00, 4'b0000, 4);
        check("frame_pulses",   32'(pulses),   32'd4);
        check("frame_numerals", 32'(numerals), 32'h5431);
        check("frame_count",    32'(frames),   32'd1);
        check("frame_timing",   32'(frame_cyc), 32'(last_valid_cyc + 1));

        // Illegal glyph must not mark its digit in the frame mask
        reset_dut();
        clear_stats();
        drive(7'h01, 4'b0001, 6);
        drive(7'h06, 4'b0010, 6);
        drive(7'h5B, 4'b0100, 6);
        drive(7'h4F, 4'b1000, 6);
        drive(7'h00, 4'b0000, 4);
        check("illegal_mask_frames",   32'(frames),   32'd0);
        check("illegal_mask_numerals", 32'(numerals), 32'h3210);
        drive(7'h3F, 4'b0001, 6);
        drive(7'h00, 4'b0000, 4);
        check("completed_frames",   32'(frames),   32'd1);
        check("completed_numerals", 32'(numerals), 32'h3210);
        check("completed_pulses",   32'(pulses),   32'd5);

        // Reset in the middle of a stable run
        reset_dut();
        drive(7'h06, 4'b0001, 6);
        drive(7'h00, 4'b0000, 4);
        check("pre_mid_numerals", 32'(numerals), 32'h0001);
        clear_stats();
        drive(7'h6F, 4'b0010, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_numerals", 32'(numerals), 32'h0000);
        check("mid_rst_pulses",   32'(pulses),   32'd0);
        clear_stats();
        drive(7'h6F, 4'b0010, 8);
        drive(7'h00, 4'b0000, 4);
        check("post_rst_pulses",   32'(pulses),          32'd1);
        check("post_rst_latency",  32'(first_pulse_cyc), 32'd5);
        check("post_rst_numerals", 32'(numerals),        32'h0090);
        check("post_rst_digit",    32'(out_digit),       32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
